// File: rtl/cpu_pkg.sv
// Shared register-file constants and the writeback entry record.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Register 0 is hard-wired; writes to it are dropped.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] val;
  } wb_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Combinational youngest-match search over the pending writeback entries.
// Entries are walked from head (oldest) towards tail (youngest), so the last
// match found is the youngest one and supplies the value.
module fwd_lookup
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        entry_addr [DEPTH],
  input  logic [DATA_W-1:0]        entry_val  [DEPTH],
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest over the occupied slots; a later match overrides.
  always_comb begin
    hit = 1'b0;
    val = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (lookup_addr != '0) &&
          (entry_addr[idx] == lookup_addr)) begin
        hit = 1'b1;
        val = entry_val[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback buffer in front of the register file write port.
// Accepts results over valid/ready, drains one per cycle unless stalled,
// and exposes two forwarding lookups over the not-yet-written entries.
module writeback_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_wb_valid,
  output logic                     o_wb_ready,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_val,
  input  logic                     i_wb_stall,
  output logic [ADDR_W-1:0]        o_regW_addr,
  output logic [DATA_W-1:0]        o_regW_val,
  output logic                     o_RegWrite,
  input  logic [ADDR_W-1:0]        i_fwd1_addr,
  input  logic [ADDR_W-1:0]        i_fwd2_addr,
  output logic                     o_fwd1_hit,
  output logic                     o_fwd2_hit,
  output logic [DATA_W-1:0]        o_fwd1_val,
  output logic [DATA_W-1:0]        o_fwd2_val,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; never reset, only the occupancy range is meaningful.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] val_mem  [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic push_en;
  logic pop_en;

  // Ready depends on registered occupancy only, never on the same-cycle pop.
  assign o_wb_ready = (count_reg != CNT_W'(DEPTH));
  assign o_empty    = (count_reg == '0);
  assign o_count    = count_reg;
  assign o_RegWrite = !o_empty && !i_wb_stall;
  assign pop_en     = o_RegWrite;
  // Writes to register 0 are handshaken but never stored.
  assign push_en    = i_wb_valid && o_wb_ready && (i_wb_addr != ADDR_W'(REG_ZERO));

  assign o_regW_addr = o_empty ? '0 : addr_mem[head_reg];
  assign o_regW_val  = o_empty ? '0 : val_mem[head_reg];

  // Pointer and occupancy update for push, pop, or both together.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push_en) begin
      tail_next = tail_reg + PTR_W'(1);
    end
    if (pop_en) begin
      head_next = head_reg + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Control state register; reset flushes every pending entry.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Store an accepted entry at the tail slot.
  always_ff @(posedge i_clock) begin
    if (push_en) begin
      addr_mem[tail_reg] <= i_wb_addr;
      val_mem[tail_reg]  <= i_wb_val;
    end
  end

  // Two identical forwarding ports share one lookup implementation.
  logic [1:0][ADDR_W-1:0] fwd_addr;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_val;

  assign fwd_addr[0] = i_fwd1_addr;
  assign fwd_addr[1] = i_fwd2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_fwd (
        .head        (head_reg),
        .count       (count_reg),
        .entry_addr  (addr_mem),
        .entry_val   (val_mem),
        .lookup_addr (fwd_addr[gi]),
        .hit         (fwd_hit[gi]),
        .val         (fwd_val[gi])
      );
    end
  endgenerate

  assign o_fwd1_hit = fwd_hit[0];
  assign o_fwd2_hit = fwd_hit[1];
  assign o_fwd1_val = fwd_val[0];
  assign o_fwd2_val = fwd_val[1];

endmodule

// File: tb/tb_writeback_queue.sv
// Directed, table-driven bench for writeback_queue with a small register
// file model fed from the drain port.
module tb_writeback_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        i_clock;
  logic        i_reset;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_val;
  logic        i_wb_stall;
  logic [4:0]  o_regW_addr;
  logic [31:0] o_regW_val;
  logic        o_RegWrite;
  logic [4:0]  i_fwd1_addr;
  logic [4:0]  i_fwd2_addr;
  logic        o_fwd1_hit;
  logic        o_fwd2_hit;
  logic [31:0] o_fwd1_val;
  logic [31:0] o_fwd2_val;
  logic [2:0]  o_count;
  logic        o_empty;

  writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_wb_valid  (i_wb_valid),
    .o_wb_ready  (o_wb_ready),
    .i_wb_addr   (i_wb_addr),
    .i_wb_val    (i_wb_val),
    .i_wb_stall  (i_wb_stall),
    .o_regW_addr (o_regW_addr),
    .o_regW_val  (o_regW_val),
    .o_RegWrite  (o_RegWrite),
    .i_fwd1_addr (i_fwd1_addr),
    .i_fwd2_addr (i_fwd2_addr),
    .o_fwd1_hit  (o_fwd1_hit),
    .o_fwd2_hit  (o_fwd2_hit),
    .o_fwd1_val  (o_fwd1_val),
    .o_fwd2_val  (o_fwd2_val),
    .o_count     (o_count),
    .o_empty     (o_empty)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Register file model: commits whatever the drain port presents at the edge.
  logic [31:0] rf [32];
  int          wr_count = 0;
  wb_entry_t   wlog [$];

  always @(posedge i_clock) begin
    if (o_RegWrite) begin
      rf[o_regW_addr] = o_regW_val;
      wlog.push_back('{addr: o_regW_addr, val: o_regW_val});
      wr_count++;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] val;
    logic        stall;
    logic [4:0]  f1;
    logic [4:0]  f2;
    logic        rdy;
    logic [2:0]  cnt;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wv;
    logic        h1;
    logic [31:0] v1;
    logic        h2;
    logic [31:0] v2;
  } vec_t;

  vec_t vt [15];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    i_reset = 1'b1; i_wb_valid = 1'b0; i_wb_addr = '0; i_wb_val = '0;
    i_wb_stall = 1'b0; i_fwd1_addr = '0; i_fwd2_addr = '0;
    step(); step();
    i_reset = 1'b0;
    #1;
    // Reset state.
    check("rst_ready", o_wb_ready, 1);
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_regwrite", o_RegWrite, 0);
    check("rst_waddr", o_regW_addr, 0);
    check("rst_wval", o_regW_val, 0);
    check("rst_fwd1_hit", o_fwd1_hit, 0);
    check("rst_fwd2_hit", o_fwd2_hit, 0);

    // Single push (3,4): written the next cycle.
    i_wb_valid = 1'b1; i_wb_addr = 5'd3; i_wb_val = 32'd4;
    #1;
    check("p1_ready", o_wb_ready, 1);
    check("p1_rw_before", o_RegWrite, 0);
    step();
    i_wb_valid = 1'b0;
    #1;
    check("p1_rw", o_RegWrite, 1);
    check("p1_waddr", o_regW_addr, 3);
    check("p1_wval", o_regW_val, 4);
    step();
    check("p1_rf3", rf[3], 4);
    check("p1_empty", o_empty, 1);

    // Table: stall fill, ordered drain, zero-address push, same-cycle forward.
    //           valid addr val stall f1 f2 | rdy cnt rw wa wv  h1 v1 h2 v2
    vt[0]  = '{1, 2, 6, 1, 2, 5,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    vt[1]  = '{1, 2, 7, 1, 2, 5,  1, 1, 0, 2, 6,  1, 6, 0, 0};
    vt[2]  = '{1, 5, 9, 1, 2, 5,  1, 2, 0, 2, 6,  1, 7, 0, 0};
    vt[3]  = '{1, 1, 1, 1, 2, 5,  1, 3, 0, 2, 6,  1, 7, 1, 9};
    vt[4]  = '{1, 7, 7, 1, 2, 5,  0, 4, 0, 2, 6,  1, 7, 1, 9};
    vt[5]  = '{0, 0, 0, 0, 2, 5,  0, 4, 1, 2, 6,  1, 7, 1, 9};
    vt[6]  = '{0, 0, 0, 0, 2, 5,  1, 3, 1, 2, 7,  1, 7, 1, 9};
    vt[7]  = '{0, 0, 0, 0, 2, 5,  1, 2, 1, 5, 9,  0, 0, 1, 9};
    vt[8]  = '{0, 0, 0, 0, 2, 5,  1, 1, 1, 1, 1,  0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 2, 5,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    vt[10] = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    vt[12] = '{1, 4, 5, 0, 0, 4,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 4,  1, 1, 1, 4, 5,  0, 0, 1, 5};
    vt[14] = '{0, 0, 0, 0, 0, 4,  1, 0, 0, 0, 0,  0, 0, 0, 0};

    wlog.delete();
    for (int i = 0; i < 15; i++) begin
      i_wb_valid = vt[i].valid; i_wb_addr = vt[i].addr; i_wb_val = vt[i].val;
      i_wb_stall = vt[i].stall; i_fwd1_addr = vt[i].f1; i_fwd2_addr = vt[i].f2;
      #1;
      check($sformatf("v%0d_ready", i), o_wb_ready, vt[i].rdy);
      check($sformatf("v%0d_count", i), o_count, vt[i].cnt);
      check($sformatf("v%0d_empty", i), o_empty, (vt[i].cnt == 0));
      check($sformatf("v%0d_rw", i), o_RegWrite, vt[i].rw);
      check($sformatf("v%0d_waddr", i), o_regW_addr, vt[i].wa);
      check($sformatf("v%0d_wval", i), o_regW_val, vt[i].wv);
      check($sformatf("v%0d_h1", i), o_fwd1_hit, vt[i].h1);
      check($sformatf("v%0d_v1", i), o_fwd1_val, vt[i].v1);
      check($sformatf("v%0d_h2", i), o_fwd2_hit, vt[i].h2);
      check($sformatf("v%0d_v2", i), o_fwd2_val, vt[i].v2);
      step();
    end
    i_wb_valid = 1'b0; i_fwd1_addr = '0; i_fwd2_addr = '0;
    check("tbl_rf2", rf[2], 7);
    check("tbl_rf5", rf[5], 9);
    check("tbl_rf1", rf[1], 1);
    check("tbl_rf4", rf[4], 5);
    check("tbl_rf7_untouched", rf[7], 0);
    check("tbl_rf0_untouched", rf[0], 0);
    check("tbl_log_size", wlog.size(), 5);
    if (wlog.size() == 5) begin
      check("tbl_order0", {wlog[0].addr, wlog[0].val[7:0]}, {5'd2, 8'd6});
      check("tbl_order1", {wlog[1].addr, wlog[1].val[7:0]}, {5'd2, 8'd7});
      check("tbl_order2", {wlog[2].addr, wlog[2].val[7:0]}, {5'd5, 8'd9});
      check("tbl_order3", {wlog[3].addr, wlog[3].val[7:0]}, {5'd1, 8'd1});
      check("tbl_order4", {wlog[4].addr, wlog[4].val[7:0]}, {5'd4, 8'd5});
    end

    // Back-to-back pushes with no stall: occupancy stays at most 1.
    for (int k = 1; k <= 8; k++) begin
      i_wb_valid = 1'b1; i_wb_addr = 5'(k); i_wb_val = 32'(k + 10);
      #1;
      check($sformatf("b2b%0d_ready", k), o_wb_ready, 1);
      check($sformatf("b2b%0d_count_le1", k), (o_count <= 3'd1), 1);
      step();
    end
    i_wb_valid = 1'b0;
    step(); step();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("b2b_rf%0d", k), rf[k], 32'(k + 10));
    end
    check("b2b_empty", o_empty, 1);

    // Reset mid-operation flushes stalled entries without writing them.
    i_wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_wb_valid = 1'b1; i_wb_addr = 5'(10 + k); i_wb_val = 32'(100 + k);
      step();
    end
    i_wb_valid = 1'b0;
    #1;
    check("flush_count_before", o_count, 3);
    begin
      int wc;
      wc = wr_count;
      i_reset = 1'b1;
      step();
      i_reset = 1'b0; i_wb_stall = 1'b0;
      #1;
      check("flush_count", o_count, 0);
      check("flush_rw", o_RegWrite, 0);
      check("flush_empty", o_empty, 1);
      step(); step(); step();
      check("flush_no_writes", wr_count, wc);
    end
    check("flush_rf10", rf[10], 0);
    check("flush_rf11", rf[11], 0);
    check("flush_rf12", rf[12], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
